// File: rtl/rfifo_fwft_out.sv
// Read-side FWFT output adapter for the dual-clock FIFO: credit-limited pop
// issue into a 3-entry register buffer presenting a valid/ready stream.
module rfifo_fwft_out #(
    parameter int unsigned DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [1:0]       m_count
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned OCC_W = 3;

    logic             init_done;
    logic             inflight;
    logic             valid_q;
    logic [1:0]       count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DSIZE-1:0] mem [DEPTH];

    logic             pop;
    logic             deq;
    logic [OCC_W-1:0] occupancy;
    logic [1:0]       count_next;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;

    // Pop issue: words held plus the one in flight must leave room for another.
    always_comb begin
        occupancy = OCC_W'(count) + OCC_W'(inflight);
        rinc      = init_done & ~rempty & (occupancy < OCC_W'(DEPTH));
        pop       = rinc & ~rempty;
    end

    // Buffer bookkeeping; pointers wrap 2 -> 0.
    always_comb begin
        deq        = valid_q & m_ready;
        count_next = 2'(count + 2'(inflight) - 2'(deq));
        head_next  = head;
        tail_next  = tail;
        if (deq) begin
            head_next = (head == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(head + 1'b1);
        end
        if (inflight) begin
            tail_next = (tail == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(tail + 1'b1);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            init_done <= 1'b0;
            inflight  <= 1'b0;
            valid_q   <= 1'b0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            init_done <= 1'b1;
            inflight  <= pop;
            valid_q   <= (count_next != 2'd0);
            count     <= count_next;
            head      <= head_next;
            tail      <= tail_next;
            if (inflight) begin
                mem[tail] <= rdata;
            end
        end
    end

    // Head word comes straight from storage; no bypass from rdata.
    always_comb begin
        case (head)
            2'd0:    m_data = mem[0];
            2'd1:    m_data = mem[1];
            default: m_data = mem[2];
        endcase
    end

    assign m_valid = valid_q;
    assign m_count = count;

endmodule

// File: tb/tb_rfifo_fwft_out.sv
// Bench for rfifo_fwft_out: directed scenarios plus random traffic compared
// against a queue-based model of the output stream.
module tb_rfifo_fwft_out;

    localparam int unsigned DSIZE = 8;

    logic             rclk;
    logic             rrst_n;
    logic             rempty;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic [1:0]       m_count;

    int vectors;
    int miscompares;

    // Reference model: words buffered, word in flight, startup guard.
    logic [DSIZE-1:0] mq[$];
    bit               md_infl;
    bit               md_init;
    int               avail;
    logic [DSIZE-1:0] next_word;

    rfifo_fwft_out #(.DSIZE(DSIZE)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rinc    (rinc),
        .rdata   (rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rclk cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input bit re, input bit rdy);
        bit exp_rinc;
        bit deq;
        @(negedge rclk);
        rempty  = re || (avail == 0);
        m_ready = rdy;
        rdata   = md_infl ? next_word : DSIZE'($urandom);
        #1;
        exp_rinc = md_init && !rempty && ((mq.size() + int'(md_infl)) < 3);
        chk("rinc", 32'(rinc), 32'(exp_rinc));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        chk("m_count", 32'(m_count), 32'(mq.size()));
        if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        deq = (mq.size() != 0) && rdy;
        @(posedge rclk);
        if (deq) void'(mq.pop_front());
        if (md_infl) begin
            mq.push_back(rdata);
            next_word = DSIZE'(next_word + 1'b1);
        end
        md_infl = exp_rinc;
        if (exp_rinc) avail--;
        md_init = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_count"}, 32'(m_count), 32'd0);
        chk({tag, "_rinc"},    32'(rinc),    32'd0);
        chk({tag, "_m_data"},  32'(m_data),  32'd0);
    endtask

    // Asynchronous reset mid-cycle; release shortly after a rising edge.
    task automatic mid_reset();
        @(negedge rclk);
        rempty = 1'b0;
        #2 rrst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        mq.delete();
        md_infl = 1'b0;
        md_init = 1'b0;
        @(posedge rclk);
        #3 rrst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        md_infl     = 1'b0;
        md_init     = 1'b0;
        avail       = 0;
        next_word   = '0;
        rrst_n      = 1'b0;
        rempty      = 1'b0;
        m_ready     = 1'b0;
        rdata       = '0;
        #2 check_reset_outputs("por");
        @(posedge rclk);
        #3 rrst_n = 1'b1;

        // Startup guard: rempty reads 0 in the first cycle but no pop may issue.
        avail = 100;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Single word 0xA5.
        avail = 1; next_word = 8'hA5;
        repeat (5) step(1'b0, 1'b1);

        // Burst of 8 words 0x00..0x07 with the consumer always ready.
        avail = 8; next_word = 8'h00;
        repeat (12) step(1'b0, 1'b1);

        // Backpressure on a 5-word FIFO, then release.
        avail = 5; next_word = 8'h10;
        repeat (8) step(1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b1);

        // Reset with two words buffered and one in flight.
        avail = 100; next_word = 8'h40;
        repeat (3) step(1'b0, 1'b0);
        mid_reset();
        step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b1);

        // Random traffic.
        avail = 100000; next_word = 8'h80;
        repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);

        // Drain.
        repeat (6) step(1'b1, 1'b1);
        chk("drained_count", 32'(m_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
